// File: rtl/cordic_seq_if.sv
// Handshake bundle between the NCO phase sequencer, the CORDIC core and the
// octant mirror stage.
interface cordic_seq_if #(
    parameter int PHASE_W = 32,
    parameter int ANGLE_W = 16
);
    logic               en;
    logic               sample_tick;
    logic [PHASE_W-1:0] fcw;
    logic               fcw_ld;
    logic               cordic_start;
    logic [ANGLE_W-1:0] cordic_angle;
    logic               cordic_done;
    logic [2:0]         index_qua;
    logic               trans_in;
    logic               overrun;
    logic               timeout;

    modport slave (
        input  en, sample_tick, fcw, fcw_ld, cordic_done,
        output cordic_start, cordic_angle, index_qua, trans_in, overrun, timeout
    );

    modport master (
        output en, sample_tick, fcw, fcw_ld, cordic_done,
        input  cordic_start, cordic_angle, index_qua, trans_in, overrun, timeout
    );
endinterface

// File: rtl/cordic_seq.sv
// Phase accumulator and sequencer that feeds one residual angle per sample
// tick to an iterative CORDIC core and forwards its completion to the mirror stage.
//
// state  | meaning
// IDLE   | waiting for an enabled sample tick
// LAUNCH | angle/octant captured, cordic_start issued on exit
// WAIT   | core busy, counting cycles toward the timeout
// ISSUE  | trans_in high for the mirror stage
module cordic_seq #(
    parameter int PHASE_W = 32,
    parameter int ANGLE_W = 16,
    parameter int TMO     = 32
) (
    input logic         clk,
    input logic         reset,
    cordic_seq_if.slave bus
);
    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_step;
    logic [ANGLE_W-1:0] r_angle;
    logic [2:0]         r_index;
    logic               r_start;
    logic               r_trans;
    logic               r_overrun;
    logic               r_timeout;

    logic               w_tick;
    logic               w_capture;
    logic               w_start_nxt;
    logic               w_trans_nxt;
    logic               w_tmo_set;
    logic [2:0]         w_oct;
    logic [ANGLE_W-1:0] w_res;
    logic               w_unused;

    assign w_tick = bus.en & bus.sample_tick;
    assign w_oct  = r_phase[PHASE_W-1 -: 3];
    assign w_res  = r_phase[PHASE_W-4 -: ANGLE_W];
    // phase LSBs below the residual window never reach the core
    assign w_unused = ^r_phase[PHASE_W-4-ANGLE_W:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_capture   = 1'b0;
        w_start_nxt = 1'b0;
        w_trans_nxt = 1'b0;
        w_tmo_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_start_nxt = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cordic_done) begin
                    w_trans_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (r_cnt == CNT_W'(TMO - 1)) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_trans <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_start_nxt;
            r_trans <= w_trans_nxt;
        end
    end

    // accumulator runs on every enabled tick, even while a sample is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
            r_step  <= '0;
        end else begin
            if (bus.fcw_ld) r_step <= bus.fcw;
            if (w_tick)     r_phase <= r_phase + r_step;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_angle <= '0;
            r_index <= '0;
        end else if (w_capture) begin
            r_angle <= w_oct[0] ? ~w_res : w_res;
            r_index <= w_oct;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            if (w_tmo_set)                     r_timeout <= 1'b1;
        end
    end

    assign bus.cordic_start = r_start;
    assign bus.cordic_angle = r_angle;
    assign bus.index_qua    = r_index;
    assign bus.trans_in     = r_trans;
    assign bus.overrun      = r_overrun;
    assign bus.timeout      = r_timeout;
endmodule

// File: tb/tb_cordic_seq.sv
// Directed and randomized checks of cordic_seq against an arithmetic model of
// the phase accumulator, octant split and handshake timing.
module tb_cordic_seq;
    localparam int PHASE_W = 32;
    localparam int ANGLE_W = 16;
    localparam int TMO     = 32;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_start = 0;
    int   n_trans = 0;

    longint unsigned m_phase;
    longint unsigned m_step;
    logic            m_ovr;
    logic            m_tmo;

    cordic_seq_if #(.PHASE_W(PHASE_W), .ANGLE_W(ANGLE_W)) bus ();

    cordic_seq #(.PHASE_W(PHASE_W), .ANGLE_W(ANGLE_W), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cordic_start === 1'b1) n_start++;
        if (bus.trans_in === 1'b1)     n_trans++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_start"}, {31'd0, bus.cordic_start}, 32'd0);
        chk({tag, "_angle"}, {16'd0, bus.cordic_angle}, 32'd0);
        chk({tag, "_index"}, {29'd0, bus.index_qua}, 32'd0);
        chk({tag, "_trans"}, {31'd0, bus.trans_in}, 32'd0);
        chk({tag, "_ovr"},   {31'd0, bus.overrun}, 32'd0);
        chk({tag, "_tmo"},   {31'd0, bus.timeout}, 32'd0);
        chk({tag, "_phase"}, dut.r_phase, 32'd0);
    endtask

    // asserted mid-cycle so the zero outputs can only come from the async path
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1 chk_zero_outputs("rst");
        m_phase = 0; m_step = 0; m_ovr = 1'b0; m_tmo = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] v);
        @(posedge clk); #1 bus.fcw = v; bus.fcw_ld = 1'b1;
        @(posedge clk); #1 bus.fcw_ld = 1'b0;
        m_step = v;
    endtask

    function automatic logic [31:0] exp_oct(input longint unsigned ph);
        return 32'(ph / (64'd1 << 29));
    endfunction

    function automatic logic [31:0] exp_angle(input longint unsigned ph);
        longint unsigned r;
        r = (ph / (64'd1 << 13)) % 65536;
        if (exp_oct(ph) % 2 == 1) r = 65535 - r;
        return 32'(r);
    endfunction

    // one full sample: tick, launch, core answers after d cycles, trans_in
    task automatic sample(input int d, input bit en_drop, input bit imm);
        logic [31:0] eo, ea;
        int          t0;
        eo = exp_oct(m_phase);
        ea = exp_angle(m_phase);
        m_phase = (m_phase + m_step) % (64'd1 << 32);
        t0 = n_trans;
        if (!imm) begin @(posedge clk); #1; end
        bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        if (en_drop) bus.en = 1'b0;
        chk("start_early", {31'd0, bus.cordic_start}, 32'd0);
        @(posedge clk); #1;
        chk("start_lat", {31'd0, bus.cordic_start}, 32'd1);
        chk("angle", {16'd0, bus.cordic_angle}, ea);
        chk("octant", {29'd0, bus.index_qua}, eo);
        for (int i = 0; i < d; i++) begin
            if (en_drop && i == 0) bus.sample_tick = 1'b1;
            @(posedge clk); #1;
            bus.sample_tick = 1'b0;
            if (i == 0) chk("start_1cyc", {31'd0, bus.cordic_start}, 32'd0);
        end
        bus.cordic_done = 1'b1;
        @(posedge clk); #1 bus.cordic_done = 1'b0;
        chk("trans_lat", {31'd0, bus.trans_in}, 32'd1);
        chk("angle_hold", {16'd0, bus.cordic_angle}, ea);
        chk("octant_hold", {29'd0, bus.index_qua}, eo);
        @(posedge clk); #1;
        chk("trans_1cyc", {31'd0, bus.trans_in}, 32'd0);
        chk("trans_count", 32'(n_trans - t0), 32'd1);
        chk("phase", dut.r_phase, 32'(m_phase));
        chk("ovr_flag", {31'd0, bus.overrun}, {31'd0, m_ovr});
        chk("tmo_flag", {31'd0, bus.timeout}, {31'd0, m_tmo});
        bus.en = 1'b1;
    endtask

    initial begin
        int s0, t0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.sample_tick = 1'b0; bus.fcw = '0;
        bus.fcw_ld = 1'b0; bus.cordic_done = 1'b0;
        m_phase = 0; m_step = 0; m_ovr = 1'b0; m_tmo = 1'b0;
        #12 chk_zero_outputs("por");
        @(posedge clk); #1 rst_n = 1'b1; bus.en = 1'b1;
        // first tick on the very first edge after release
        sample(3, 0, 1);

        // step 1/16 turn: second sample lands halfway into octant 0
        load(32'h1000_0000);
        sample(5, 0, 0);
        sample(5, 0, 0);

        // eight octants in sequence
        do_reset();
        load(32'h2000_0000);
        t0 = n_trans;
        for (int k = 0; k < 8; k++) sample(5, 0, 0);
        chk("eight_trans", 32'(n_trans - t0), 32'd8);

        // silent wrap from 0xF000_0000
        load(32'hF000_0000);
        sample(3, 0, 0);
        chk("pre_wrap", dut.r_phase, 32'hF000_0000);
        load(32'h2000_0000);
        sample(3, 0, 0);
        chk("wrap", dut.r_phase, 32'h1000_0000);

        // overrun: second tick arrives while the core is busy
        s0 = n_start; t0 = n_trans;
        m_phase = (m_phase + 2 * m_step) % (64'd1 << 32);
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        chk("ovr_before", {31'd0, bus.overrun}, 32'd0);
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
        m_ovr = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.cordic_done = 1'b1;
        @(posedge clk); #1 bus.cordic_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_one_start", 32'(n_start - s0), 32'd1);
        chk("ovr_one_trans", 32'(n_trans - t0), 32'd1);
        chk("ovr_phase", dut.r_phase, 32'(m_phase));

        // timeout: core never answers
        t0 = n_trans;
        m_phase = (m_phase + m_step) % (64'd1 << 32);
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        @(posedge clk); #1;
        chk("tmo_start", {31'd0, bus.cordic_start}, 32'd1);
        repeat (TMO - 1) @(posedge clk);
        #1 chk("tmo_not_yet", {31'd0, bus.timeout}, 32'd0);
        @(posedge clk); #1;
        chk("tmo_set", {31'd0, bus.timeout}, 32'd1);
        m_tmo = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("tmo_no_trans", 32'(n_trans - t0), 32'd0);
        sample(4, 0, 0);

        // en low: ticks ignored entirely
        bus.en = 1'b0;
        s0 = n_start;
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("en0_no_start", 32'(n_start - s0), 32'd0);
        chk("en0_phase", dut.r_phase, 32'(m_phase));
        bus.en = 1'b1;

        // en dropped mid-operation: sample still completes, busy tick ignored
        sample(6, 1, 0);

        // reset during WAIT, late done must not produce trans_in
        @(posedge clk); #1 bus.sample_tick = 1'b1;
        @(posedge clk); #1 bus.sample_tick = 1'b0;
        @(posedge clk); #1;
        chk("rw_start", {31'd0, bus.cordic_start}, 32'd1);
        @(posedge clk); #1;
        t0 = n_trans;
        do_reset();
        bus.cordic_done = 1'b1;
        @(posedge clk); #1 bus.cordic_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rw_no_trans", 32'(n_trans - t0), 32'd0);

        // randomized step words and core latencies
        load($urandom);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) load($urandom);
            sample($urandom_range(1, 20), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
